// File: rtl/spectro_pkg.sv
// spectro_pkg -- shared definitions for the spectrometer window counters
// and the downstream frame sender.
//
// Contents:
//   CNT_W         width of every count / snapshot word
//   NUM_CH        number of event channels (CH1..CH15)
//   SEL_INDEX     sel code that reads the window index word
//   SEL_CH_BASE   sel code of CH1; CHn is read with sel == SEL_CH_BASE + n - 1
//   CNT_MAX       saturation value of a count word
//   sat_inc()     saturating +0/+1 on a count word
package spectro_pkg;

  localparam int CNT_W  = 12;
  localparam int NUM_CH = 15;

  localparam logic [3:0] SEL_INDEX   = 4'd0;
  localparam logic [3:0] SEL_CH_BASE = 4'd1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Adds inc to v, sticking at CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    logic [CNT_W-1:0] r;
    r = v;
    if (inc && (v != CNT_MAX)) r = v + CNT_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/spectro_sat_counter.sv
// spectro_sat_counter -- one live event counter: CNT_W bits, increment
// enable, synchronous clear, saturating at CNT_MAX.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset (count -> 0)
//   inc_i  add one this cycle (ignored once saturated)
//   clr_i  synchronous clear; wins over inc_i
//   cnt_o  current count
module spectro_sat_counter
  import spectro_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = sat_inc(cnt_q, inc_i);
    if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/spectro_window_counters.sv
// spectro_window_counters -- counts events on 15 channels over fixed windows
// of WINDOW_LEN clock cycles and hands each closed window to a frame sender
// as a snapshot (15 channel counts plus a 12-bit window index).
//
// Parameters:
//   WINDOW_LEN  window length in clk cycles (2..65535)
//
// Ports:
//   clk       clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   ch_evt    [14:0] channel events, bit i-1 = CHi
//   clr       one-cycle release from the sender once the frame is sent
//   sel       [3:0] word select: 0 = window index, n = CHn
//   data_out  [11:0] selected snapshot word (combinational from sel)
//   ovf       snapshot-ready level to the sender
//   overrun   sticky: a window closed while a snapshot was still pending
//
// Build option:
//   SPECTRO_EDGE_DETECT_EN  defined: each ch_evt bit goes through a 2-flop
//                           synchroniser and only 0->1 transitions count
//                           (3 cycles input to counter). Undefined: ch_evt is
//                           synchronous and counts once per cycle high.
//
// Sender handshake: ovf rises the cycle after a window closes and stays high
// until the sender pulses clr; the snapshot is frozen for that whole time, so
// the sender may walk sel freely. A clr seen while ovf is low is ignored. If
// clr coincides with a window end, the new window is captured and ovf stays
// high (the release is consumed by the new capture rather than lost).
module spectro_window_counters
  import spectro_pkg::*;
#(
  parameter int WINDOW_LEN = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_evt,
  input  logic              clr,
  input  logic [3:0]        sel,
  output logic [CNT_W-1:0]  data_out,
  output logic              ovf,
  output logic              overrun
);

  localparam int               TMR_W    = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_LEN - 1);

  // run_q holds the timer at 0 for the first edge after reset release, so
  // the first window is a full WINDOW_LEN cycles rather than a partial one.
  logic                          run_q;
  logic [TMR_W-1:0]              tmr_q, tmr_d;
  logic [CNT_W-1:0]              idx_q, idx_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  snap_ch_q, snap_ch_d;
  logic [CNT_W-1:0]              snap_idx_q, snap_idx_d;
  logic                          ovf_q, ovf_d;
  logic                          overrun_q, overrun_d;

  logic [NUM_CH-1:0]             evt_raw;
  logic [NUM_CH-1:0]             qev;
  logic [NUM_CH-1:0][CNT_W-1:0]  live_cnt;
  logic                          win_end;
  logic                          capture;

`ifdef SPECTRO_EDGE_DETECT_EN
  logic [NUM_CH-1:0] sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= ch_evt;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign evt_raw = sync2_q & ~prev_q;
`else
  assign evt_raw = ch_evt;
`endif

  assign qev     = run_q ? evt_raw : '0;
  assign win_end = run_q && (tmr_q == TMR_LAST);
  assign capture = win_end && (!ovf_q || clr);

  // Counters clear on every window end; an event on that same cycle is
  // folded into the snapshot value below instead.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    spectro_sat_counter u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (qev[g]),
      .clr_i (win_end),
      .cnt_o (live_cnt[g])
    );
  end

  always_comb begin
    tmr_d      = tmr_q;
    idx_d      = idx_q;
    snap_ch_d  = snap_ch_q;
    snap_idx_d = snap_idx_q;
    ovf_d      = ovf_q;
    overrun_d  = overrun_q;

    if (run_q) tmr_d = win_end ? '0 : tmr_q + TMR_W'(1);

    if (win_end) begin
      idx_d = idx_q + CNT_W'(1);
      if (capture) begin
        for (int i = 0; i < NUM_CH; i++) snap_ch_d[i] = sat_inc(live_cnt[i], qev[i]);
        snap_idx_d = idx_q;
        ovf_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (clr && ovf_q) begin
      snap_ch_d  = '0;
      snap_idx_d = '0;
      ovf_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      tmr_q      <= '0;
      idx_q      <= '0;
      snap_ch_q  <= '0;
      snap_idx_q <= '0;
      ovf_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      tmr_q      <= tmr_d;
      idx_q      <= idx_d;
      snap_ch_q  <= snap_ch_d;
      snap_idx_q <= snap_idx_d;
      ovf_q      <= ovf_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    if (sel == SEL_INDEX) data_out = snap_idx_q;
    else                  data_out = snap_ch_q[sel - SEL_CH_BASE];
  end

  assign ovf     = ovf_q;
  assign overrun = overrun_q;

endmodule
